// File: rtl/regbank_pkg.sv
// regbank_pkg: shared widths, FSM states and grant encoding for the register bank write path
package regbank_pkg;

    localparam int REG_DATA_W = 16;
    localparam int REG_ADDR_W = 3;
    localparam int REG_NUM    = 8;

    typedef enum logic {
        WA_INIT,
        WA_RUN
    } wa_state_t;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/regbank_write_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant; the last-grant pointer lives in the parent
module rr_arb2
    import regbank_pkg::*;
(
    input  logic enable,
    input  logic aValid,
    input  logic bValid,
    input  logic lastGrant,
    output logic aGrant,
    output logic bGrant
);

    // A lone requester always wins; under contention the one not granted last time wins
    always_comb begin
        aGrant = enable && aValid && (!bValid || lastGrant == GRANT_B);
        bGrant = enable && bValid && (!aValid || lastGrant == GRANT_A);
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: round-robin sharing of the registerBank write port between requesters A and B
// Optional post-reset clear sweep enabled by defining REGBANK_WA_CLEAR_EN.
module regbank_write_arbiter
    import regbank_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              a_ready,
    output logic              b_ready,
    output logic              WE,
    output logic [ADDR_W-1:0] inAddr,
    output logic [DATA_W-1:0] inData,
    output logic              busy,
    output logic              last_grant
);

    if (NUM_REGS != (1 << ADDR_W)) begin : gBadCfg
        $error("NUM_REGS must equal 2**ADDR_W");
    end

    logic              running;
    logic              clearActive;
    logic [ADDR_W-1:0] clearAddr;
    logic              weQ;

`ifdef REGBANK_WA_CLEAR_EN
    wa_state_t         state;
    wa_state_t         stateNext;
    logic [ADDR_W-1:0] clearCnt;

    // State register plus the sweep address counter, which only advances while clearing
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WA_INIT;
            clearCnt <= '0;
        end else begin
            state    <= stateNext;
            clearCnt <= (state == WA_INIT) ? clearCnt + 1'b1 : '0;
        end
    end

    // Leave the sweep once the last register address has been issued
    always_comb begin
        stateNext = (state == WA_INIT && clearCnt == ADDR_W'(NUM_REGS - 1)) ? WA_RUN : state;
    end

    // Requesters are only served in RUN and never while reset is held
    always_comb begin
        clearActive = (state == WA_INIT);
        busy        = clearActive;
        running     = (state == WA_RUN) && !rst;
        clearAddr   = clearCnt;
    end
`else
    assign clearActive = 1'b0;
    assign clearAddr   = '0;
    assign busy        = 1'b0;
    assign running     = !rst;
`endif

    rr_arb2 uArb (
        .enable   (running),
        .aValid   (a_valid),
        .bValid   (b_valid),
        .lastGrant(last_grant),
        .aGrant   (a_ready),
        .bGrant   (b_ready)
    );

    // Single output stage: sweep writes first, otherwise register whichever request was accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            weQ        <= 1'b0;
            inAddr     <= '0;
            inData     <= '0;
            last_grant <= GRANT_B;
        end else if (clearActive) begin
            weQ    <= 1'b1;
            inAddr <= clearAddr;
            inData <= '0;
        end else begin
            weQ <= a_ready || b_ready;
            if (a_ready) begin
                inAddr     <= a_addr;
                inData     <= a_data;
                last_grant <= GRANT_A;
            end else if (b_ready) begin
                inAddr     <= b_addr;
                inData     <= b_data;
                last_grant <= GRANT_B;
            end
        end
    end

    // Masking with rst drops a registered write that reset catches before the bank samples it
    assign WE = weQ && !rst;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb_regbank_write_arbiter: directed scoreboard bench for regbank_write_arbiter with a behavioural register bank
module tb_regbank_write_arbiter;

`ifdef REGBANK_WA_CLEAR_EN
    localparam logic CLEAR = 1'b1;
`else
    localparam logic CLEAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic [2:0]  a_addr, b_addr;
    logic [15:0] a_data, b_data;
    logic        a_ready, b_ready, WE, busy, last_grant;
    logic [2:0]  inAddr;
    logic [15:0] inData;

    logic [15:0] mem [8];
    logic [15:0] expMem [8];
    logic [18:0] q [$];
    logic        mLast;
    logic [2:0]  lastAddr;
    logic [15:0] lastData;
    logic        pendV = 1'b0;
    logic [2:0]  pendA;
    logic [15:0] pendD;
    int          total = 0;
    int          passed = 0;

    regbank_write_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data),
        .a_ready(a_ready), .b_ready(b_ready),
        .WE(WE), .inAddr(inAddr), .inData(inData),
        .busy(busy), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (WE) mem[inAddr] <= inData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        if (pendV) expMem[pendA] = pendD;
        pendV = 1'b0;
    endtask

    task automatic doSweep();
`ifdef REGBANK_WA_CLEAR_EN
        for (int i = 0; i < 8; i++) begin
            tick();
            #1;
            chk($sformatf("sweep%0d_we", i), WE, 1);
            chk($sformatf("sweep%0d_addr", i), inAddr, i);
            chk($sformatf("sweep%0d_data", i), inData, 0);
            chk($sformatf("sweep%0d_busy", i), busy, (i < 7) ? 1 : 0);
            pendV = 1'b1; pendA = 3'(i); pendD = 16'h0000;
            lastAddr = 3'(i); lastData = 16'h0000;
        end
`endif
    endtask

    task automatic doReset(input logic hv, input string tag);
        rst = 1'b1;
        a_valid = hv; a_addr = 3'd7; a_data = 16'hAAAA;
        b_valid = hv; b_addr = 3'd7; b_data = 16'hBBBB;
        pendV = 1'b0;
        q.delete();
        #1;
        chk({tag, "_we_now"}, WE, 0);
        tick();
        #1;
        chk({tag, "_we"}, WE, 0);
        chk({tag, "_addr"}, inAddr, 0);
        chk({tag, "_data"}, inData, 0);
        chk({tag, "_last"}, last_grant, 1);
        chk({tag, "_a_ready"}, a_ready, 0);
        chk({tag, "_b_ready"}, b_ready, 0);
        chk({tag, "_busy"}, busy, CLEAR);
        mLast = 1'b1; lastAddr = 3'd0; lastData = 16'h0000;
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        doSweep();
    endtask

    task automatic step(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                        input logic bv, input logic [2:0] ba, input logic [15:0] bd, input string tag);
        logic        ea, eb;
        logic [18:0] e;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        ea = av && (!bv || mLast == 1'b1);
        eb = bv && (!av || mLast == 1'b0);
        @(negedge clk);
        chk({tag, "_a_ready"}, a_ready, ea);
        chk({tag, "_b_ready"}, b_ready, eb);
        if (ea) begin q.push_back({aa, ad}); mLast = 1'b0; end
        else if (eb) begin q.push_back({ba, bd}); mLast = 1'b1; end
        tick();
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_we"}, WE, 1);
            chk({tag, "_addr"}, inAddr, e[18:16]);
            chk({tag, "_data"}, inData, e[15:0]);
            lastAddr = e[18:16]; lastData = e[15:0];
            pendV = 1'b1; pendA = e[18:16]; pendD = e[15:0];
        end else begin
            chk({tag, "_we"}, WE, 0);
            chk({tag, "_addr_hold"}, inAddr, lastAddr);
            chk({tag, "_data_hold"}, inData, lastData);
        end
        chk({tag, "_last"}, last_grant, mLast);
        chk({tag, "_busy"}, busy, 0);
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        doReset(1'b1, "reset");
`ifdef REGBANK_WA_CLEAR_EN
        step(0, 0, 0, 0, 0, 0, "postsweep");
        for (int i = 0; i < 8; i++) chk($sformatf("clear_mem%0d", i), mem[i], 16'h0000);
`endif
        step(1, 3'd2, 16'h35A1, 0, 3'd0, 16'h0000, "singleA");
        step(0, 0, 0, 0, 0, 0, "idle1");
        chk("mem2", mem[2], expMem[2]);
        for (int i = 0; i < 4; i++)
            step(1, 3'd1, 16'h1234, 1, 3'd5, 16'h65DF, $sformatf("cont%0d", i));
        step(1, 3'd4, 16'h12CE, 1, 3'd4, 16'hEFD3, "same0");
        step(1, 3'd4, 16'h12CE, 0, 3'd4, 16'hEFD3, "same1");
        step(0, 0, 0, 0, 0, 0, "idle2");
        chk("mem1", mem[1], expMem[1]);
        chk("mem5", mem[5], expMem[5]);
        chk("mem4", mem[4], 16'h12CE);
        step(0, 3'd0, 16'h0000, 1, 3'd6, 16'h0A5A, "singleB");
        step(0, 0, 0, 0, 0, 0, "idle3");
        chk("mem6_pre", mem[6], 16'h0A5A);
        step(1, 3'd6, 16'hEFD3, 0, 3'd0, 16'h0000, "preRst");
        doReset(1'b0, "midRst");
        step(0, 0, 0, 0, 0, 0, "idle4");
        chk("mem6_post", mem[6], CLEAR ? 16'h0000 : 16'h0A5A);
        chk("mem6_model", mem[6], expMem[6]);
        step(1, 3'd3, 16'h3333, 1, 3'd3, 16'hC3C3, "postRstCont");
        step(0, 0, 0, 0, 0, 0, "idle5");
        chk("mem3", mem[3], 16'h3333);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
